sipo_deserializer: RTL and testbench

- Serial-in/parallel-out stage that consumes a one-bit-per-clock stream (the Q stream of a DFF chain) and assembles WIDTH-bit words.
- Presents each completed word on a double-buffered output register with a valid/ready handshake, so the next frame can shift in while the previous word waits.
- Sits directly downstream of the single-bit DFF storage stage, in front of word-wide datapath registers.

---
 rtl/sipo_deserializer_pkg.sv | 13 +
 rtl/sipo_deserializer_shift_reg.sv | 41 ++++
 rtl/sipo_deserializer.sv | 145 ++++++++++++++
 tb/tb_sipo_deserializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_t    : frame FSM encoding (IDLE = waiting for start, SHIFT = mid-frame)
//   DEF_WIDTH  : default word length in bits
package sipo_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/sipo_deserializer_shift_reg.sv
// Serial shift register for sipo_deserializer.
//   clk, rst  : clock, asynchronous active-high reset (contents -> 0)
//   enable    : shift bit_in into the register
//   load      : discard contents and load bit_in as the first bit of a frame
//   bit_in    : serial data bit
//   q         : current shift contents
// MSB_FIRST=1 shifts left and inserts at the LSB, so the first bit ends up in
// q[WIDTH-1] after WIDTH bits; MSB_FIRST=0 shifts right and inserts at the MSB.
module sipo_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {q[WIDTH-2:0], bit_in};
      assign first   = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin : g_lsb
      assign shifted = {bit_in, q[WIDTH-1:1]};
      assign first   = {bit_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // load has priority: a resync start replaces whatever was partially shifted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (load)   q <= first;
    else if (enable) q <= shifted;
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a double-buffered output word.
//   clk, rst    : clock, asynchronous active-high reset
//   bit_in      : serial data bit, sampled when bit_valid is high
//   bit_valid   : qualifies bit_in and start
//   start       : bit_in is bit 0 of a new frame
//   data_out    : last completed word
//   data_valid  : data_out holds an unconsumed word
//   data_ready  : consumer takes data_out when data_valid && data_ready
//   busy        : a frame is partially received
//   frame_err   : one-cycle pulse when start arrives mid-frame
//   overrun     : sticky, a completed word was dropped; cleared by clr_ovr
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sr_en, sr_load;
  logic            complete, resync;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk    (clk),
    .rst    (rst),
    .enable (sr_en),
    .load   (sr_load),
    .bit_in (bit_in),
    .q      (sr_q)
  );

  // The completing bit is still on bit_in, so the finished word is the
  // register contents with that bit folded in; this lets data_out update on
  // the same edge that samples the last bit.
  generate
    if (MSB_FIRST) begin : g_word_msb
      assign word = {sr_q[WIDTH-2:0], bit_in};
    end else begin : g_word_lsb
      assign word = {bit_in, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_en    = 1'b0;
    sr_load  = 1'b0;
    complete = 1'b0;
    resync   = 1'b0;
    case (state_q)
      IDLE: begin
        // bits without start are ignored while idle
        if (bit_valid && start) begin
          sr_load = 1'b1;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (start) begin
            // start outranks completion: a start on what would have been the
            // last bit restarts the frame and produces no word
            sr_load = 1'b1;
            cnt_d   = CW'(1);
            resync  = 1'b1;
          end else if (cnt_q == LAST) begin
            sr_en    = 1'b1;
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            sr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= resync;
  end

  // Output buffer: a new word may replace the pending one only if the
  // consumer takes the pending one on the same edge; otherwise the new word
  // is dropped and overrun records it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (complete) begin
      if (!data_valid || data_ready) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // set beats clear when both happen on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        overrun <= 1'b0;
    else if (complete && data_valid && !data_ready) overrun <= 1'b1;
    else if (clr_ovr)                               overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one MSB-first and one LSB-first instance share
// the same stimulus; a frame-level model (list of received bits, words built
// arithmetically) predicts every output after every edge.
module tb_sipo_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_bi = 1'b0, r_bv = 1'b0, r_st = 1'b0, r_rdy = 1'b1, r_clr = 1'b0;

  logic [W-1:0] dout_m, dout_l;
  logic dv_m, dv_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l;

  int total = 0;
  int bad   = 0;

  // model state
  bit           in_frame = 1'b0;
  int           nb = 0;
  bit           fbits[W];
  logic [W-1:0] e_m = '0, e_l = '0;
  bit           e_dv = 1'b0, e_ovr = 1'b0, e_ferr = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(r_bi), .bit_valid(r_bv), .start(r_st),
    .data_out(dout_m), .data_valid(dv_m), .data_ready(r_rdy), .busy(busy_m),
    .frame_err(ferr_m), .overrun(ovr_m), .clr_ovr(r_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(r_bi), .bit_valid(r_bv), .start(r_st),
    .data_out(dout_l), .data_valid(dv_l), .data_ready(r_rdy), .busy(busy_l),
    .frame_err(ferr_l), .overrun(ovr_l), .clr_ovr(r_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0; nb = 0;
    e_m = '0; e_l = '0; e_dv = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0;
  endtask

  // applies the inputs that were present at the edge just taken
  task automatic model_step();
    bit done = 1'b0;
    bit dv_old;
    int wm = 0, wl = 0;
    e_ferr = 1'b0;
    if (r_bv) begin
      if (r_st) begin
        e_ferr = in_frame;
        in_frame = 1'b1;
        fbits[0] = r_bi;
        nb = 1;
      end else if (in_frame) begin
        fbits[nb] = r_bi;
        nb++;
        if (nb == W) begin
          done = 1'b1; in_frame = 1'b0; nb = 0;
        end
      end
    end
    if (done)
      for (int i = 0; i < W; i++) begin
        wm += int'(fbits[i]) * (1 << (W - 1 - i));
        wl += int'(fbits[i]) * (1 << i);
      end
    dv_old = e_dv;
    if (done) begin
      if (!dv_old || r_rdy) begin
        e_m = W'(wm); e_l = W'(wl); e_dv = 1'b1;
      end
    end else if (dv_old && r_rdy) begin
      e_dv = 1'b0;
    end
    if (done && dv_old && !r_rdy) e_ovr = 1'b1;
    else if (r_clr)               e_ovr = 1'b0;
  endtask

  task automatic check_all();
    chk("dout_m", 32'(dout_m), 32'(e_m));
    chk("dout_l", 32'(dout_l), 32'(e_l));
    chk("valid",  {30'b0, dv_m, dv_l},     {30'b0, e_dv, e_dv});
    chk("busy",   {30'b0, busy_m, busy_l}, {30'b0, in_frame, in_frame});
    chk("ferr",   {30'b0, ferr_m, ferr_l}, {30'b0, e_ferr, e_ferr});
    chk("ovr",    {30'b0, ovr_m, ovr_l},   {30'b0, e_ovr, e_ovr});
  endtask

  task automatic step(input logic v, input logic s, input logic b);
    r_bv = v; r_st = s; r_bi = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // seq[W-1] is transmitted first
  task automatic send_seq(input logic [W-1:0] seq, input int gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), seq[W-1-i]);
      if (i < W - 1) repeat (gap) step(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  int busy_cnt;

  initial begin
    model_reset();
    #12;
    chk("rst_dout", {16'b0, dout_m, dout_l}, 32'h0);
    chk("rst_flags", {24'b0, dv_m, dv_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1: A5 MSB-first, data_valid for exactly one cycle, busy for 7
    r_rdy = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), 1'(8'hA5 >> (W - 1 - i)));
      if (busy_m) busy_cnt++;
    end
    chk("t1_word", 32'(dout_m), 32'hA5);
    chk("t1_valid", 32'(dv_m), 32'h1);
    chk("t1_busy_cycles", busy_cnt, 7);
    idle(1);
    chk("t1_valid_drop", 32'(dv_m), 32'h0);

    // 2: bits 1,1,0,0,0,0,0,0 -> LSB-first word 03
    send_seq(8'b1100_0000, 0);
    chk("t2_word_l", 32'(dout_l), 32'h03);
    idle(2);

    // 3: consumer stalled, back-to-back 3C then F0
    r_rdy = 1'b0;
    send_seq(8'h3C, 0);
    send_seq(8'hF0, 0);
    chk("t3_hold", 32'(dout_m), 32'h3C);
    chk("t3_valid", 32'(dv_m), 32'h1);
    chk("t3_ovr", 32'(ovr_m), 32'h1);
    r_clr = 1'b1; idle(1); r_clr = 1'b0;
    chk("t3_clr", 32'(ovr_m), 32'h0);
    r_rdy = 1'b1;
    idle(2);

    // 4: restart after 4 bits, then 1111_0000
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_ferr", 32'(ferr_m), 32'h1);
    for (int i = 1; i < W; i++) begin
      step(1'b1, 1'b0, (i < 4));
      if (i == 1) chk("t4_ferr_pulse", 32'(ferr_m), 32'h0);
    end
    chk("t4_word", 32'(dout_m), 32'hF0);
    idle(2);

    // 5: 3-cycle gaps between bits of 5A
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), 1'(8'h5A >> (W - 1 - i)));
      if (i == W - 2) chk("t5_not_yet", 32'(busy_m), 32'h1);
      if (i < W - 1) idle(3);
    end
    chk("t5_word", 32'(dout_m), 32'h5A);
    idle(2);

    // 6: async reset mid-frame with a pending word
    r_rdy = 1'b0;
    send_seq(8'h77, 0);
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'($urandom));
    chk("t6_pending", 32'(dv_m), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    r_rdy = 1'b1;
    idle(1);
    send_seq(8'h81, 0);
    chk("t6_word", 32'(dout_m), 32'h81);
    chk("t6_no_ferr", 32'(ferr_m), 32'h0);
    idle(2);

    // random traffic, including starts on the completing bit and stalls
    for (int n = 0; n < 600; n++) begin
      r_rdy = ($urandom_range(0, 99) < 60);
      r_clr = ($urandom_range(0, 99) < 5);
      step(($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 8), 1'($urandom));
    end
    r_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
